// File: rtl/dmac_read_responder.sv
// dmac_read_responder: AXI4 read-channel slave serving one burst at a time
// from a synchronous single-port memory (read data one cycle after strobe).
// Supports FIXED/INCR/WRAP bursts and narrow sizes; illegal requests are
// answered with SLVERR beats at normal timing without touching memory.
module dmac_read_responder #(
  parameter int ADDR_WD = 32,
  parameter int DATA_WD = 32,
  parameter int MEM_AW  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_axi_arvalid,
  output logic               s_axi_arready,
  input  logic [ADDR_WD-1:0] s_axi_araddr,
  input  logic [7:0]         s_axi_arlen,
  input  logic [2:0]         s_axi_arsize,
  input  logic [1:0]         s_axi_arburst,
  output logic               s_axi_rvalid,
  input  logic               s_axi_rready,
  output logic [DATA_WD-1:0] s_axi_rdata,
  output logic [1:0]         s_axi_rresp,
  output logic               s_axi_rlast,
  output logic               mem_rd_en,
  output logic [MEM_AW-1:0]  mem_rd_addr,
  input  logic [DATA_WD-1:0] mem_rd_data
);

  localparam int STRB_WD   = DATA_WD / 8;
  localparam int LANE_BITS = $clog2(STRB_WD);
  localparam logic [2:0] MAX_SIZE = 3'(LANE_BITS);

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [1:0] BURST_RSVD  = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_RESP
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_WD-1:0]   addr_q, addr_d;
  logic [7:0]           len_q, len_d;
  logic [2:0]           size_q, size_d;
  logic [1:0]           burst_q, burst_d;
  logic                 err_q, err_d;
  logic [7:0]           beat_cnt_q, beat_cnt_d;
  logic                 rvalid_q, rvalid_d;
  logic [DATA_WD-1:0]   rdata_q, rdata_d;
  logic [1:0]           rresp_q, rresp_d;
  logic                 rlast_q, rlast_d;

  logic                 ar_hs;
  logic                 ar_err;
  logic [ADDR_WD-1:0]   ar_size_mask;
  logic [ADDR_WD-1:0]   beat_bytes;
  logic [ADDR_WD-1:0]   size_mask;
  logic [ADDR_WD-1:0]   wrap_mask;
  logic [ADDR_WD-1:0]   next_addr;

  // Accept a request only when idle; reset holds the channel closed.
  assign s_axi_arready = (state_q == S_IDLE) && !rst;
  assign ar_hs         = s_axi_arvalid && s_axi_arready;

  assign s_axi_rvalid = rvalid_q;
  assign s_axi_rdata  = rdata_q;
  assign s_axi_rresp  = rresp_q;
  assign s_axi_rlast  = rlast_q;

  // Classify an incoming request as illegal (whole burst answered SLVERR).
  always_comb begin
    ar_size_mask = (ADDR_WD'(1) << s_axi_arsize) - ADDR_WD'(1);
    ar_err = 1'b0;
    if (s_axi_arburst == BURST_RSVD) begin
      ar_err = 1'b1;
    end
    if (s_axi_arsize > MAX_SIZE) begin
      ar_err = 1'b1;
    end
    if (s_axi_arburst == BURST_WRAP) begin
      if (!(s_axi_arlen inside {8'd1, 8'd3, 8'd7, 8'd15})) begin
        ar_err = 1'b1;
      end
      if ((s_axi_araddr & ar_size_mask) != '0) begin
        ar_err = 1'b1;
      end
    end
  end

  // Address of the following beat; INCR realigns after an unaligned first beat.
  always_comb begin
    beat_bytes = ADDR_WD'(1) << size_q;
    size_mask  = beat_bytes - ADDR_WD'(1);
    wrap_mask  = ((ADDR_WD'(len_q) + ADDR_WD'(1)) << size_q) - ADDR_WD'(1);
    case (burst_q)
      BURST_FIXED: next_addr = addr_q;
      BURST_INCR:  next_addr = (addr_q & ~size_mask) + beat_bytes;
      BURST_WRAP:  next_addr = (addr_q & ~wrap_mask) | ((addr_q + beat_bytes) & wrap_mask);
      default:     next_addr = addr_q;
    endcase
  end

  // Burst sequencer: fetch -> load -> present, one beat every three cycles.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    size_d      = size_q;
    burst_d     = burst_q;
    err_d       = err_q;
    beat_cnt_d  = beat_cnt_q;
    rvalid_d    = rvalid_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    rlast_d     = rlast_q;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    case (state_q)
      S_IDLE: begin
        if (ar_hs) begin
          addr_d     = s_axi_araddr;
          len_d      = s_axi_arlen;
          size_d     = s_axi_arsize;
          burst_d    = s_axi_arburst;
          err_d      = ar_err;
          beat_cnt_d = 8'd0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        // Error bursts keep the same timing but never strobe the memory.
        mem_rd_en   = !err_q;
        mem_rd_addr = addr_q[LANE_BITS +: MEM_AW];
        state_d     = S_LOAD;
      end
      S_LOAD: begin
        rdata_d  = err_q ? '0 : mem_rd_data;
        rresp_d  = err_q ? RESP_SLVERR : RESP_OKAY;
        rlast_d  = (beat_cnt_q == len_q);
        rvalid_d = 1'b1;
        state_d  = S_RESP;
      end
      S_RESP: begin
        if (s_axi_rready) begin
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
          if (rlast_q) begin
            state_d = S_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
            addr_d     = next_addr;
            state_d    = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; synchronous reset discards any burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      err_q      <= 1'b0;
      beat_cnt_q <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= '0;
      rlast_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      err_q      <= err_d;
      beat_cnt_q <= beat_cnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rlast_q    <= rlast_d;
    end
  end

endmodule
